// File: rtl/sync_seq_ctrl.sv
// Initiator-side sequencer for the template/offset sync engine: streams the template
// and observation windows into the engine, then waits for its offset answer.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i; no samples accepted
// CFG   | template capture, accepted samples strobed with sync_cfg_en_o
// DIFF  | observation window, accepted samples strobed with sync_diff_en_o
// WAIT  | waiting for the engine's offset-done pulse, timeout running
// DONE  | offset latched, done_o high for this single cycle
module sync_seq_ctrl #(
    parameter int DATA_W            = 16,
    parameter int TMP_WINDOW_LENGTH = 800,
    parameter int OBS_WINDOW_FACTOR = 2,
    parameter int CNT_W             = 12,
    parameter int TIMEOUT_CYC       = 4096,
    parameter int TO_W              = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              smp_valid_i,
    input  logic [DATA_W-1:0] smp_data_i,
    output logic              smp_ready_o,
    output logic              sync_cfg_en_o,
    output logic              sync_diff_en_o,
    output logic [DATA_W-1:0] sync_data_o,
    input  logic              sync_offset_done_i,
    input  logic [DATA_W-1:0] sync_offset_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [DATA_W-1:0] offset_o
);

    localparam int OBS_LEN = OBS_WINDOW_FACTOR * TMP_WINDOW_LENGTH;
    localparam logic [CNT_W-1:0] TMP_LAST = CNT_W'(TMP_WINDOW_LENGTH - 1);
    localparam logic [CNT_W-1:0] OBS_LAST = CNT_W'(OBS_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CFG  = 3'd1,
        S_DIFF = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] smp_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             accept;

    // Ready is decoded straight from state so the CFG->DIFF handover has no bubble.
    assign smp_ready_o = (state == S_CFG) || (state == S_DIFF);
    assign accept      = smp_valid_i && smp_ready_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            smp_cnt        <= '0;
            to_cnt         <= '0;
            sync_cfg_en_o  <= 1'b0;
            sync_diff_en_o <= 1'b0;
            sync_data_o    <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            timeout_o      <= 1'b0;
            offset_o       <= '0;
        end else begin
            // A completed handshake is always forwarded, even in an abort cycle.
            sync_cfg_en_o  <= accept && (state == S_CFG);
            sync_diff_en_o <= accept && (state == S_DIFF);
            if (accept) begin
                sync_data_o <= smp_data_i;
            end
            done_o    <= 1'b0;
            timeout_o <= 1'b0;

            if (abort_i) begin
                state   <= S_IDLE;
                smp_cnt <= '0;
                to_cnt  <= '0;
                busy_o  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            state   <= S_CFG;
                            smp_cnt <= '0;
                            to_cnt  <= '0;
                            busy_o  <= 1'b1;
                        end
                    end
                    S_CFG: begin
                        if (accept) begin
                            if (smp_cnt == TMP_LAST) begin
                                state   <= S_DIFF;
                                smp_cnt <= '0;
                            end else begin
                                smp_cnt <= smp_cnt + 1'b1;
                            end
                        end
                    end
                    S_DIFF: begin
                        if (accept) begin
                            if (smp_cnt == OBS_LAST) begin
                                state   <= S_WAIT;
                                smp_cnt <= '0;
                                to_cnt  <= '0;
                            end else begin
                                smp_cnt <= smp_cnt + 1'b1;
                            end
                        end
                    end
                    S_WAIT: begin
                        // Checking done first lets a late answer beat the timeout.
                        if (sync_offset_done_i) begin
                            offset_o <= sync_offset_i;
                            done_o   <= 1'b1;
                            state    <= S_DONE;
                            to_cnt   <= '0;
                        end else if (to_cnt == TO_LAST) begin
                            timeout_o <= 1'b1;
                            state     <= S_IDLE;
                            busy_o    <= 1'b0;
                            to_cnt    <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
